// File: rtl/windowed_regfile.sv
// SPARC-style windowed register file: 3 combinational read ports, 1 write port, CWP-remapped r8-r31.
// Latency: reads 0 cycles (optional same-cycle bypass), writes and CWP updates land at the edge; no backpressure.
module windowed_regfile #(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 8,
  parameter bit BYPASS   = 1'b1,
  localparam int CW      = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ra,
  input  logic [4:0]       rb,
  input  logic [4:0]       rc,
  output logic [WIDTH-1:0] pa,
  output logic [WIDTH-1:0] pb,
  output logic [WIDTH-1:0] pc,
  input  logic             we,
  input  logic [4:0]       rw,
  input  logic [WIDTH-1:0] wd,
  input  logic             cwp_save,
  input  logic             cwp_restore,
  input  logic             cwp_load,
  input  logic [CW-1:0]    cwp_in,
  output logic [CW-1:0]    cwp
);

  localparam int NPHYS = 8 + 16 * NWINDOWS;
  localparam int PAW   = $clog2(NPHYS);
  localparam logic [CW-1:0] LASTW = CW'(NWINDOWS - 1);

  logic [WIDTH-1:0] r_mem [NPHYS];
  logic [CW-1:0]    r_cwp;

  logic [CW-1:0]    w_cwp_nxt;
  logic             w_wr;
  logic [PAW-1:0]   w_waddr;
  logic [4:0]       w_raddr [3];
  logic [WIDTH-1:0] w_rdat  [3];

  // Ins of window w share storage with the outs of window w+1 (mod NWINDOWS).
  function automatic logic [PAW-1:0] phys(input logic [4:0] r, input logic [CW-1:0] w);
    logic [CW-1:0]  wn;
    logic [PAW-1:0] off;
    wn  = (w == LASTW) ? '0 : w + CW'(1);
    off = PAW'(r[2:0]);
    case (r[4:3])
      2'd0:    phys = PAW'(r);
      2'd1:    phys = PAW'(8)  + (PAW'(w) << 4) + off;
      2'd2:    phys = PAW'(16) + (PAW'(w) << 4) + off;
      default: phys = PAW'(8)  + (PAW'(wn) << 4) + off;
    endcase
  endfunction

  assign w_wr    = we && (rw != 5'd0);
  assign w_waddr = phys(rw, r_cwp);

  always_comb begin
    w_cwp_nxt = r_cwp;
    if (cwp_load) begin
      // cwp_in never reaches 2*NWINDOWS, so one subtraction is the modulo.
      w_cwp_nxt = (int'(cwp_in) >= NWINDOWS) ? CW'(int'(cwp_in) - NWINDOWS) : cwp_in;
    end else if (cwp_save && !cwp_restore) begin
      w_cwp_nxt = (r_cwp == '0) ? LASTW : r_cwp - CW'(1);
    end else if (cwp_restore && !cwp_save) begin
      w_cwp_nxt = (r_cwp == LASTW) ? '0 : r_cwp + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cwp <= '0;
      for (int i = 0; i < NPHYS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_cwp <= w_cwp_nxt;
      if (w_wr) begin
        r_mem[w_waddr] <= wd;
      end
    end
  end

  assign w_raddr[0] = ra;
  assign w_raddr[1] = rb;
  assign w_raddr[2] = rc;

  // Bypass compares physical addresses, so aliased in/out names forward too.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      w_rdat[p] = '0;
      if (w_raddr[p] != 5'd0) begin
        if (BYPASS && w_wr && !reset && (phys(w_raddr[p], r_cwp) == w_waddr)) begin
          w_rdat[p] = wd;
        end else begin
          w_rdat[p] = r_mem[phys(w_raddr[p], r_cwp)];
        end
      end
    end
  end

  assign pa  = w_rdat[0];
  assign pb  = w_rdat[1];
  assign pc  = w_rdat[2];
  assign cwp = r_cwp;

endmodule

// File: tb/tb_windowed_regfile.sv
// Directed bench for windowed_regfile: 8-window bypass, 8-window no-bypass and 5-window instances share stimulus.
module tb_windowed_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra, rb, rc, rw;
  logic        we;
  logic [31:0] wd;
  logic        cwp_save, cwp_restore, cwp_load;
  logic [2:0]  cwp_in;

  logic [31:0] pa_a, pb_a, pc_a, pa_b, pb_b, pc_b, pa_c, pb_c, pc_c;
  logic [2:0]  cwp_a, cwp_b, cwp_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  windowed_regfile #(.WIDTH(32), .NWINDOWS(8), .BYPASS(1'b1)) u_a (
    .clk(clk), .reset(reset), .ra(ra), .rb(rb), .rc(rc),
    .pa(pa_a), .pb(pb_a), .pc(pc_a), .we(we), .rw(rw), .wd(wd),
    .cwp_save(cwp_save), .cwp_restore(cwp_restore), .cwp_load(cwp_load),
    .cwp_in(cwp_in), .cwp(cwp_a)
  );

  windowed_regfile #(.WIDTH(32), .NWINDOWS(8), .BYPASS(1'b0)) u_b (
    .clk(clk), .reset(reset), .ra(ra), .rb(rb), .rc(rc),
    .pa(pa_b), .pb(pb_b), .pc(pc_b), .we(we), .rw(rw), .wd(wd),
    .cwp_save(cwp_save), .cwp_restore(cwp_restore), .cwp_load(cwp_load),
    .cwp_in(cwp_in), .cwp(cwp_b)
  );

  windowed_regfile #(.WIDTH(32), .NWINDOWS(5), .BYPASS(1'b1)) u_c (
    .clk(clk), .reset(reset), .ra(ra), .rb(rb), .rc(rc),
    .pa(pa_c), .pb(pb_c), .pc(pc_c), .we(we), .rw(rw), .wd(wd),
    .cwp_save(cwp_save), .cwp_restore(cwp_restore), .cwp_load(cwp_load),
    .cwp_in(cwp_in), .cwp(cwp_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change and outputs settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; rw = 5'd0; wd = '0;
    cwp_save = 1'b0; cwp_restore = 1'b0; cwp_load = 1'b0; cwp_in = '0;
  endtask

  initial begin
    reset = 1'b1; ra = '0; rb = '0; rc = '0;
    idle();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_cwp", 32'(cwp_a), 32'd0);
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i);
      #1;
      check($sformatf("rst_r%0d", i), pa_a, 32'd0);
    end

    // r0 writes discarded
    we = 1'b1; rw = 5'd0; wd = 32'hDEADBEEF; ra = 5'd0;
    #1;
    check("r0_same_cycle", pa_a, 32'd0);
    tick();
    idle();
    #1;
    check("r0_after", pa_a, 32'd0);

    // Window overlap: r25 of window 7 is r9 of window 0
    we = 1'b1; rw = 5'd9; wd = 32'h11111111;
    tick();
    idle();
    cwp_save = 1'b1;
    tick();
    idle();
    check("save_wrap_cwp", 32'(cwp_a), 32'd7);
    ra = 5'd25;
    #1;
    check("alias_pre_write", pa_a, 32'h11111111);
    we = 1'b1; rw = 5'd25; wd = 32'h22222222;
    tick();
    idle();
    #1;
    check("r25_w7", pa_a, 32'h22222222);
    cwp_restore = 1'b1;
    tick();
    idle();
    ra = 5'd9;
    #1;
    check("restore_cwp", 32'(cwp_a), 32'd0);
    check("r9_w0_alias", pa_a, 32'h22222222);

    // Globals vs locals at CWP=2
    cwp_load = 1'b1; cwp_in = 3'd2;
    tick();
    idle();
    check("load2_cwp", 32'(cwp_a), 32'd2);
    we = 1'b1; rw = 5'd3; wd = 32'd5;
    tick();
    we = 1'b1; rw = 5'd17; wd = 32'd7;
    tick();
    idle();
    cwp_save = 1'b1;
    tick();
    idle();
    check("save_to1_cwp", 32'(cwp_a), 32'd1);
    ra = 5'd3; rb = 5'd17;
    #1;
    check("global_r3_w1", pa_a, 32'd5);
    check("local_r17_w1", pb_a, 32'd0);
    cwp_restore = 1'b1;
    tick();
    idle();
    #1;
    check("local_r17_w2", pb_a, 32'd7);

    // Bypass at CWP=2
    we = 1'b1; rw = 5'd12; wd = 32'hCAFEF00D; ra = 5'd12; rb = 5'd12; rc = 5'd12;
    #1;
    check("byp_pa", pa_a, 32'hCAFEF00D);
    check("byp_pb", pb_a, 32'hCAFEF00D);
    check("byp_pc", pc_a, 32'hCAFEF00D);
    check("nobyp_pa_old", pa_b, 32'd0);
    check("nobyp_pb_old", pb_b, 32'd0);
    tick();
    idle();
    #1;
    check("nobyp_pa_new", pa_b, 32'hCAFEF00D);
    check("byp_pa_stored", pa_a, 32'hCAFEF00D);
    // Write to a different register must not forward
    we = 1'b1; rw = 5'd13; wd = 32'h12345678; ra = 5'd12; rb = 5'd13;
    #1;
    check("byp_nomatch_pa", pa_a, 32'hCAFEF00D);
    check("byp_match_pb", pb_a, 32'h12345678);
    tick();
    idle();

    // CWP wrap and priority
    cwp_load = 1'b1; cwp_in = 3'd7;
    tick();
    idle();
    check("load7_cwp", 32'(cwp_a), 32'd7);
    cwp_restore = 1'b1;
    tick();
    idle();
    check("restore_wrap0", 32'(cwp_a), 32'd0);
    cwp_save = 1'b1;
    tick();
    idle();
    check("save_wrap7", 32'(cwp_a), 32'd7);
    cwp_save = 1'b1; cwp_restore = 1'b1;
    tick();
    idle();
    check("save_restore_hold", 32'(cwp_a), 32'd7);
    cwp_load = 1'b1; cwp_in = 3'd3; cwp_save = 1'b1;
    tick();
    idle();
    check("load_over_save", 32'(cwp_a), 32'd3);
    cwp_load = 1'b1; cwp_in = 3'd6;
    tick();
    idle();
    check("n5_load6_mod", 32'(cwp_c), 32'd1);
    check("n8_load6", 32'(cwp_a), 32'd6);

    // Write during save lands in the old window
    cwp_load = 1'b1; cwp_in = 3'd4;
    tick();
    idle();
    we = 1'b1; rw = 5'd16; wd = 32'd9; cwp_save = 1'b1;
    tick();
    idle();
    ra = 5'd16;
    #1;
    check("wsave_cwp3", 32'(cwp_a), 32'd3);
    check("wsave_r16_w3", pa_a, 32'd0);
    cwp_restore = 1'b1;
    tick();
    idle();
    #1;
    check("wsave_cwp4", 32'(cwp_a), 32'd4);
    check("wsave_r16_w4", pa_a, 32'd9);

    // Mid-sequence reset ignores same-cycle write and CWP command
    reset = 1'b1; we = 1'b1; rw = 5'd5; wd = 32'hFF; cwp_save = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    ra = 5'd16; rb = 5'd3; rc = 5'd5;
    #1;
    check("mrst_cwp", 32'(cwp_a), 32'd0);
    check("mrst_cwp_n5", 32'(cwp_c), 32'd0);
    check("mrst_r16", pa_a, 32'd0);
    check("mrst_r3", pb_a, 32'd0);
    check("mrst_r5", pc_a, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/windowed_regfile.md
# windowed_regfile

Parametrised SPARC-style windowed integer register file, the successor to the flat 32-register file built from three 32:1 read muxes. It provides three combinational read ports and one synchronous write port addressed by 5-bit architectural register numbers. A current-window-pointer (CWP) register remaps r8–r31 onto a circular bank of overlapping windows, and optional write-to-read bypass is supported. It sits in the decode/operand-fetch stage, with CWP updated by SAVE/RESTORE/WRCWP.

## Interface
- WIDTH, 32, data width of every register
- NWINDOWS, 8, number of register windows (2..32, any integer)
- BYPASS, 1, 1 = read ports return same-cycle write data on address match; 0 = read returns stored value
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all registers and CWP
- ra, rb, rc  input  5 each  architectural read addresses (rs1, rs2, rd for stores)
- pa, pb, pc  output  WIDTH each  read data
- we  input  1  write enable
- rw  input  5  architectural write address
- wd  input  WIDTH  write data
- cwp_save  input  1  decrement CWP (SAVE)
- cwp_restore  input  1  increment CWP (RESTORE)
- cwp_load  input  1  load CWP from cwp_in (WRCWP); highest priority
- cwp_in  input  CW  new CWP value, CW = max(1, $clog2(NWINDOWS))
- cwp  output  CW  current window pointer

## Operation
- Physical storage: 8 + 16·NWINDOWS entries of WIDTH bits.
- Address map, using window w = CWP:
  - r0–r7 (globals) map to phys r.
  - r8–r15 (outs) map to 8 + 16·w + (r−8).
  - r16–r23 (locals) map to 16 + 16·w + (r−16).
  - r24–r31 (ins) map to 8 + 16·((w+1) mod NWINDOWS) + (r−24).
  - Consequence: the ins of window w alias the outs of window w+1.
- r0: reads always return 0; writes to r0 are discarded (no physical entry is modified).
- Reads: combinational from the current CWP register and the addresses. Each port maps independently; all three ports may use the same address.
- Bypass (BYPASS=1): if we=1, rw≠0, and a read port's physical address equals the write's physical address, that port outputs wd in the same cycle. Otherwise it outputs the stored value. With BYPASS=0, the new value is visible from the cycle after the edge.
- Write: at the rising edge with we=1, phys(rw, CWP_current) ← wd. The write uses the CWP held before any same-edge CWP update.
- CWP update at the rising edge, in priority order:
  - reset: CWP ← 0.
  - cwp_load: CWP ← cwp_in; if cwp_in ≥ NWINDOWS, CWP ← cwp_in mod NWINDOWS.
  - cwp_save and cwp_restore both asserted: CWP unchanged.
  - cwp_save only: CWP ← (CWP = 0) ? NWINDOWS−1 : CWP−1.
  - cwp_restore only: CWP ← (CWP = NWINDOWS−1) ? 0 : CWP+1.
  - none: CWP unchanged.
- No overflow/underflow trap logic (WIM) here; the trap unit owns it. CWP simply wraps.

## Timing
- Reset (synchronous):
  - All physical entries ← 0 and CWP ← 0 at the edge where reset=1.
  - pa/pb/pc read 0 and cwp=0 from that edge onward.
  - A write or CWP command in the reset cycle is ignored.
  - Reset asserted mid-sequence discards any in-progress window state; there are no partial updates.
- Read latency: 0 cycles, combinational from ra/rb/rc, CWP and, when BYPASS=1, we/rw/wd.
- Write latency: stored at the edge, so visible on a non-bypassed read in the following cycle.
- CWP latency: the new CWP remaps reads from the cycle after the edge that updated it.
- Simultaneous write + save/restore/load: the write lands in the old window; the following cycle reads through the new window.
- No handshake; every input is sampled every cycle.

## Test plan
- Reset and r0:
  - Stimulus: assert reset one cycle, then we=1, rw=0, wd=32'hDEADBEEF; read ra=0.
  - Required: pa=0. After reset, all 32 architectural reads return 0 and cwp=0.
- Window overlap (NWINDOWS=8):
  - Stimulus: at CWP=0, write r9=32'h11111111. Then cwp_save for 1 cycle (CWP 0→7). Write r25=32'h22222222.
  - Required: CWP=7 and ra=25 reads 32'h22222222. After cwp_restore (CWP→0), r9 reads 32'h22222222, because r25 of window 7 is r9 of window 0.
- Globals and locals isolation:
  - Stimulus: write r3=5 and r17=7 at CWP=2, then cwp_save.
  - Required: r3=5 is still visible at CWP=1; r17 reads 0 at CWP=1 and 7 again back at CWP=2.
- Bypass:
  - Stimulus: BYPASS=1, we=1, rw=ra=rb=12, wd=32'hCAFEF00D in one cycle.
  - Required: pa=pb=32'hCAFEF00D in that same cycle.
  - Stimulus: repeat with BYPASS=0.
  - Required: old value in that cycle, new value in the next.
- CWP wrap and priority:
  - Stimulus: from CWP=7, cwp_restore → 0; then cwp_save → 7.
  - Required: the wraps shown above.
  - Stimulus: save and restore together.
  - Required: CWP unchanged.
  - Stimulus: cwp_load=1 with cwp_in=3 and save=1.
  - Required: CWP=3.
  - Stimulus: NWINDOWS=5, load cwp_in=6.
  - Required: CWP=1.
- Write during save:
  - Stimulus: at CWP=4, same edge we=1, rw=16, wd=9, and cwp_save=1.
  - Required: next cycle CWP=3 and r16 reads 0; after restore to 4, r16 reads 9.
